// File: rtl/bottling_line_ctrl_pkg.sv
// rtl/bottling_line_ctrl_pkg.sv - state codes and actuator decode for the fill-and-seal station
package bottling_line_ctrl_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRANSPORT = 3'd1;
    localparam logic [2:0] S_FILL      = 3'd2;
    localparam logic [2:0] S_SEAL      = 3'd3;
    localparam logic [2:0] S_ALARM     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_TRANSPORT = S_TRANSPORT,
        ST_FILL      = S_FILL,
        ST_SEAL      = S_SEAL,
        ST_ALARM     = S_ALARM
    } state_t;

    // Actuator vectors ordered {m, ve, ev, al}
    localparam logic [3:0] ACT_OFF       = 4'b0000;
    localparam logic [3:0] ACT_TRANSPORT = 4'b1000;
    localparam logic [3:0] ACT_FILL      = 4'b0100;
    localparam logic [3:0] ACT_SEAL      = 4'b0010;
    localparam logic [3:0] ACT_ALARM     = 4'b0001;

    function automatic logic [3:0] act_decode(input state_t s);
        case (s)
            ST_TRANSPORT: return ACT_TRANSPORT;
            ST_FILL:      return ACT_FILL;
            ST_SEAL:      return ACT_SEAL;
            ST_ALARM:     return ACT_ALARM;
            default:      return ACT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/batch_counter.sv
// rtl/batch_counter.sv - bottles-per-batch counter with wrapping batch count and completion pulse
module batch_counter
    import bottling_line_ctrl_pkg::*;
#(
    parameter int BATCH_SIZE = 12,
    parameter int CNT_W      = 4,
    parameter int BATCH_W    = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               inc,
    output logic [CNT_W-1:0]   unit_cnt,
    output logic [BATCH_W-1:0] batch_cnt,
    output logic               batch_done
);

    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(BATCH_SIZE - 1);

    logic [CNT_W-1:0]   unit_q, unit_d;
    logic [BATCH_W-1:0] batch_q, batch_d;
    logic               done_q, done_d;

    always_comb begin
        unit_d  = unit_q;
        batch_d = batch_q;
        done_d  = 1'b0;
        if (inc) begin
            if (unit_q == UNIT_LAST) begin
                unit_d  = '0;
                batch_d = batch_q + BATCH_W'(1);
                done_d  = 1'b1;
            end else begin
                unit_d = unit_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            unit_q  <= '0;
            batch_q <= '0;
            done_q  <= 1'b0;
        end else begin
            unit_q  <= unit_d;
            batch_q <= batch_d;
            done_q  <= done_d;
        end
    end

    assign unit_cnt   = unit_q;
    assign batch_cnt  = batch_q;
    assign batch_done = done_q;

endmodule

// File: rtl/bottling_line_ctrl.sv
// rtl/bottling_line_ctrl.sv - Moore FSM for conveyor, fill, seal and alarm with cork stock
module bottling_line_ctrl
    import bottling_line_ctrl_pkg::*;
#(
    parameter int BATCH_SIZE   = 12,
    parameter int CNT_W        = 4,
    parameter int BATCH_W      = 8,
    parameter int CORK_W       = 8,
    parameter int CORK_LOAD    = 15,
    parameter int FILL_TIMEOUT = 255,
    parameter int SEAL_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start_stop,
    input  logic               pg,
    input  logic               ch,
    input  logic               rf,
    input  logic               ack,
    output logic               m,
    output logic               ve,
    output logic               ev,
    output logic               al,
    output logic [2:0]         mef_estado,
    output logic [CNT_W-1:0]   unit_cnt,
    output logic [BATCH_W-1:0] batch_cnt,
    output logic               batch_done,
    output logic [CORK_W-1:0]  cork_cnt
);

    localparam int FT_W = $clog2(FILL_TIMEOUT + 1);
    localparam int ST_W = $clog2(SEAL_CYCLES + 1);
    localparam logic [FT_W-1:0] FILL_LAST = FT_W'(FILL_TIMEOUT - 1);
    localparam logic [ST_W-1:0] SEAL_LAST = ST_W'(SEAL_CYCLES - 1);
    localparam logic [31:0]     CORK_MAX  = 32'((64'd1 << CORK_W) - 64'd1);

    state_t            state_q, state_d;
    logic [FT_W-1:0]   fill_q, fill_d;
    logic [ST_W-1:0]   seal_q, seal_d;
    logic [CORK_W-1:0] cork_q, cork_d;
    logic              pg_q;
    logic              seal_end;
    logic [31:0]       cork_sum;

    assign seal_end = (state_q == ST_SEAL) && (seal_q == SEAL_LAST);

    // Refill and consume are summed before saturating so a coincident pair nets +CORK_LOAD-1
    always_comb begin
        cork_sum = 32'(cork_q) + (rf ? 32'(CORK_LOAD) : 32'd0) - {31'd0, seal_end};
        cork_d   = (cork_sum > CORK_MAX) ? '1 : cork_sum[CORK_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        seal_d  = seal_q;
        case (state_q)
            ST_IDLE: begin
                if (start_stop)
                    state_d = (cork_q != '0) ? ST_TRANSPORT : ST_ALARM;
            end
            ST_TRANSPORT: begin
                if (!start_stop) begin
                    state_d = ST_IDLE;
                end else if (pg && !pg_q) begin
                    state_d = ST_FILL;
                    fill_d  = '0;
                end
            end
            ST_FILL: begin
                fill_d = fill_q + FT_W'(1);
                if (ch) begin
                    state_d = ST_SEAL;
                    seal_d  = '0;
                end else if (fill_q == FILL_LAST) begin
                    state_d = ST_ALARM;
                end
            end
            ST_SEAL: begin
                seal_d = seal_q + ST_W'(1);
                if (seal_end) begin
                    if (cork_d == '0)    state_d = ST_ALARM;
                    else if (start_stop) state_d = ST_TRANSPORT;
                    else                 state_d = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (ack && cork_q != '0)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            seal_q  <= '0;
            cork_q  <= '0;
            pg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            seal_q  <= seal_d;
            cork_q  <= cork_d;
            pg_q    <= pg;
        end
    end

    batch_counter #(
        .BATCH_SIZE(BATCH_SIZE),
        .CNT_W     (CNT_W),
        .BATCH_W   (BATCH_W)
    ) u_batch (
        .clk       (clk),
        .clr       (clr),
        .inc       (seal_end),
        .unit_cnt  (unit_cnt),
        .batch_cnt (batch_cnt),
        .batch_done(batch_done)
    );

    assign {m, ve, ev, al} = act_decode(state_q);
    assign mef_estado      = state_q;
    assign cork_cnt        = cork_q;

endmodule

// File: tb/tb_bottling_line_ctrl.sv
// tb/tb_bottling_line_ctrl.sv - directed and randomized checks of bottling_line_ctrl against a cycle model
module tb_bottling_line_ctrl;

    localparam int SEAL_N = 4;
    localparam int FT     = 255;
    localparam int LOAD   = 15;

    logic clk = 1'b0;
    logic clr = 1'b0, start_stop = 1'b0, pg = 1'b0, ch = 1'b0, rf = 1'b0, ack = 1'b0;

    logic       m, ve, ev, al, batch_done_a;
    logic [2:0] mef_estado;
    logic [3:0] unit_a;
    logic [7:0] batch_a, cork_cnt;

    logic       m_b, ve_b, ev_b, al_b, batch_done_b;
    logic [2:0] mef_b;
    logic [3:0] unit_b;
    logic [7:0] batch_b, cork_b;

    bottling_line_ctrl dut_a (
        .clk(clk), .clr(clr), .start_stop(start_stop), .pg(pg), .ch(ch), .rf(rf), .ack(ack),
        .m(m), .ve(ve), .ev(ev), .al(al), .mef_estado(mef_estado),
        .unit_cnt(unit_a), .batch_cnt(batch_a), .batch_done(batch_done_a), .cork_cnt(cork_cnt)
    );

    bottling_line_ctrl #(.BATCH_SIZE(6)) dut_b (
        .clk(clk), .clr(clr), .start_stop(start_stop), .pg(pg), .ch(ch), .rf(rf), .ack(ack),
        .m(m_b), .ve(ve_b), .ev(ev_b), .al(al_b), .mef_estado(mef_b),
        .unit_cnt(unit_b), .batch_cnt(batch_b), .batch_done(batch_done_b), .cork_cnt(cork_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int done_a_seen = 0, done_b_seen = 0;

    // Reference model: 0 idle, 1 transport, 2 fill, 3 seal, 4 alarm
    int ms = 0, m_cork = 0, m_unit_a = 0, m_unit_b = 0, m_batch_a = 0, m_batch_b = 0;
    int m_fill_age = 0, m_seal_age = 0;
    bit m_done_a = 0, m_done_b = 0, m_pgq = 0;

    task automatic model_edge();
        int  nxt, nc;
        bit  consume, rise;
        if (clr) begin
            ms = 0; m_cork = 0; m_unit_a = 0; m_unit_b = 0; m_batch_a = 0; m_batch_b = 0;
            m_done_a = 0; m_done_b = 0; m_pgq = 0;
            return;
        end
        nxt = ms; consume = 0; rise = pg && !m_pgq;
        m_done_a = 0; m_done_b = 0;
        case (ms)
            0: if (start_stop) nxt = (m_cork > 0) ? 1 : 4;
            1: if (!start_stop) nxt = 0; else if (rise) begin nxt = 2; m_fill_age = 0; end
            2: begin
                m_fill_age++;
                if (ch) begin nxt = 3; m_seal_age = 0; end
                else if (m_fill_age == FT) nxt = 4;
            end
            3: begin m_seal_age++; if (m_seal_age == SEAL_N) consume = 1; end
            4: if (ack && m_cork > 0) nxt = 0;
            default: nxt = 0;
        endcase
        nc = m_cork + (rf ? LOAD : 0) - (consume ? 1 : 0);
        if (nc > 255) nc = 255;
        if (consume) begin
            m_unit_a++;
            if (m_unit_a == 12) begin m_unit_a = 0; m_batch_a = (m_batch_a + 1) % 256; m_done_a = 1; end
            m_unit_b++;
            if (m_unit_b == 6) begin m_unit_b = 0; m_batch_b = (m_batch_b + 1) % 256; m_done_b = 1; end
            nxt = (nc == 0) ? 4 : (start_stop ? 1 : 0);
        end
        m_cork = nc; ms = nxt; m_pgq = pg;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (batch_done_a === 1'b1) done_a_seen++;
        if (batch_done_b === 1'b1) done_b_seen++;
    endtask

    task automatic do_bottle(input bit rf_last);
        pg = 1; tick();
        pg = 0; ch = 1; tick();
        ch = 0;
        for (int i = 0; i < SEAL_N; i++) begin
            if (i == SEAL_N - 1) rf = rf_last;
            tick();
        end
        rf = 0;
    endtask

    task automatic test_reset();
        clr = 1; tick(); clr = 0;
        n_cmp++; if (mef_estado !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", mef_estado); end
        n_cmp++; if ({m, ve, ev, al, batch_done_a} !== 5'b0) begin n_bad++; $display("FAIL reset_outputs got %b want 00000", {m, ve, ev, al, batch_done_a}); end
        n_cmp++; if ({unit_a, batch_a, cork_cnt} !== 20'd0) begin n_bad++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", unit_a, batch_a, cork_cnt); end
    endtask

    task automatic test_first_bottle();
        int ev_cycles = 0;
        int guard = 0;
        rf = 1; tick(); rf = 0;
        n_cmp++; if (cork_cnt !== 8'd15) begin n_bad++; $display("FAIL refill_once got %0d want 15", cork_cnt); end
        start_stop = 1; tick();
        n_cmp++; if (mef_estado !== 3'd1 || m !== 1'b1) begin n_bad++; $display("FAIL start_transport got state %0d m %b want 1/1", mef_estado, m); end
        pg = 1; tick(); pg = 0;
        n_cmp++; if (ve !== 1'b1 || mef_estado !== 3'd2) begin n_bad++; $display("FAIL pg_to_fill got ve %b state %0d want 1/2", ve, mef_estado); end
        ch = 1; tick(); ch = 0;
        while (ev === 1'b1 && guard < 20) begin ev_cycles++; tick(); guard++; end
        n_cmp++; if (ev_cycles != SEAL_N) begin n_bad++; $display("FAIL seal_length got %0d want %0d", ev_cycles, SEAL_N); end
        n_cmp++; if (cork_cnt !== 8'd14 || unit_a !== 4'd1 || mef_estado !== 3'd1) begin n_bad++; $display("FAIL after_seal got cork %0d unit %0d state %0d want 14/1/1", cork_cnt, unit_a, mef_estado); end
    endtask

    task automatic test_batch();
        done_a_seen = 0; done_b_seen = 0;
        repeat (11) do_bottle(0);
        n_cmp++; if (unit_a !== 4'd0 || batch_a !== 8'd1) begin n_bad++; $display("FAIL batch12_counts got unit %0d batch %0d want 0/1", unit_a, batch_a); end
        n_cmp++; if (done_a_seen != 1) begin n_bad++; $display("FAIL batch12_done_cycles got %0d want 1", done_a_seen); end
        n_cmp++; if (unit_b !== 4'd0 || batch_b !== 8'd2) begin n_bad++; $display("FAIL batch6_counts got unit %0d batch %0d want 0/2", unit_b, batch_b); end
        n_cmp++; if (done_b_seen != 2) begin n_bad++; $display("FAIL batch6_done_cycles got %0d want 2", done_b_seen); end
        n_cmp++; if (cork_cnt !== 8'd3) begin n_bad++; $display("FAIL batch_corks got %0d want 3", cork_cnt); end
    endtask

    task automatic test_timeout();
        int ve_cycles = 0;
        int guard = 0;
        pg = 1; tick(); pg = 0;
        while (al !== 1'b1 && guard < 400) begin
            if (ve === 1'b1) ve_cycles++;
            tick(); guard++;
        end
        n_cmp++; if (ve_cycles != FT || al !== 1'b1) begin n_bad++; $display("FAIL fill_timeout got %0d ve cycles al %b want %0d/1", ve_cycles, al, FT); end
        ack = 1; tick(); ack = 0;
        n_cmp++; if (mef_estado !== 3'd0) begin n_bad++; $display("FAIL timeout_ack got state %0d want 0", mef_estado); end
    endtask

    task automatic test_cork_empty();
        tick();
        do_bottle(0); do_bottle(0);
        n_cmp++; if (cork_cnt !== 8'd1) begin n_bad++; $display("FAIL cork_one got %0d want 1", cork_cnt); end
        do_bottle(0);
        n_cmp++; if (mef_estado !== 3'd4 || al !== 1'b1 || cork_cnt !== 8'd0) begin n_bad++; $display("FAIL empty_alarm got state %0d al %b cork %0d want 4/1/0", mef_estado, al, cork_cnt); end
        ack = 1; tick(); ack = 0;
        n_cmp++; if (mef_estado !== 3'd4) begin n_bad++; $display("FAIL ack_empty_holds got state %0d want 4", mef_estado); end
        rf = 1; tick(); rf = 0;
        ack = 1; tick(); ack = 0;
        n_cmp++; if (mef_estado !== 3'd0 || cork_cnt !== 8'd15) begin n_bad++; $display("FAIL refill_ack got state %0d cork %0d want 0/15", mef_estado, cork_cnt); end
    endtask

    task automatic test_saturation();
        clr = 1; tick(); clr = 0;
        start_stop = 0;
        rf = 1; repeat (18) tick(); rf = 0;
        n_cmp++; if (cork_cnt !== 8'd255) begin n_bad++; $display("FAIL refill_saturate got %0d want 255", cork_cnt); end
        start_stop = 1; tick();
        repeat (5) do_bottle(0);
        n_cmp++; if (cork_cnt !== 8'd250) begin n_bad++; $display("FAIL cork_250 got %0d want 250", cork_cnt); end
        do_bottle(1);
        n_cmp++; if (cork_cnt !== 8'd255 || mef_estado !== 3'd1) begin n_bad++; $display("FAIL rf_on_seal got cork %0d state %0d want 255/1", cork_cnt, mef_estado); end
    endtask

    task automatic test_clr_mid_seal();
        pg = 1; tick(); pg = 0;
        ch = 1; tick(); ch = 0;
        tick();
        pg = 1; clr = 1; tick(); clr = 0;
        n_cmp++; if (mef_estado !== 3'd0 || {m, ve, ev, al, batch_done_a} !== 5'b0) begin n_bad++; $display("FAIL clr_outputs got state %0d act %b want 0/00000", mef_estado, {m, ve, ev, al, batch_done_a}); end
        n_cmp++; if ({unit_a, batch_a, cork_cnt} !== 20'd0) begin n_bad++; $display("FAIL clr_counters got %0d/%0d/%0d want 0/0/0", unit_a, batch_a, cork_cnt); end
        start_stop = 0; rf = 1; tick(); rf = 0;
        start_stop = 1; tick();
        repeat (3) tick();
        n_cmp++; if (mef_estado !== 3'd1 || ve !== 1'b0) begin n_bad++; $display("FAIL pg_level_ignored got state %0d ve %b want 1/0", mef_estado, ve); end
        pg = 0; tick(); pg = 1; tick(); pg = 0;
        n_cmp++; if (mef_estado !== 3'd2 || ve !== 1'b1) begin n_bad++; $display("FAIL pg_new_edge got state %0d ve %b want 2/1", mef_estado, ve); end
    endtask

    task automatic test_random();
        logic [3:0] exp_act;
        clr = 1; tick(); clr = 0;
        for (int i = 0; i < 4000; i++) begin
            start_stop = ($urandom_range(0, 9) != 0);
            pg  = ($urandom_range(0, 3) == 0);
            ch  = ($urandom_range(0, 15) == 0);
            rf  = ($urandom_range(0, 24) == 0);
            ack = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 799) == 0);
            tick();
            exp_act = {ms == 1, ms == 2, ms == 3, ms == 4};
            n_cmp++; if (mef_estado !== 3'(ms) || {m, ve, ev, al} !== exp_act) begin n_bad++; $display("FAIL rand_state cyc %0d got %0d/%b want %0d/%b", i, mef_estado, {m, ve, ev, al}, ms, exp_act); end
            n_cmp++; if (cork_cnt !== 8'(m_cork)) begin n_bad++; $display("FAIL rand_cork cyc %0d got %0d want %0d", i, cork_cnt, m_cork); end
            n_cmp++; if (unit_a !== 4'(m_unit_a) || batch_a !== 8'(m_batch_a) || batch_done_a !== m_done_a) begin n_bad++; $display("FAIL rand_batch12 cyc %0d got %0d/%0d/%b want %0d/%0d/%b", i, unit_a, batch_a, batch_done_a, m_unit_a, m_batch_a, m_done_a); end
            n_cmp++; if (unit_b !== 4'(m_unit_b) || batch_b !== 8'(m_batch_b) || batch_done_b !== m_done_b) begin n_bad++; $display("FAIL rand_batch6 cyc %0d got %0d/%0d/%b want %0d/%0d/%b", i, unit_b, batch_b, batch_done_b, m_unit_b, m_batch_b, m_done_b); end
        end
        clr = 0;
    endtask

    initial begin
        test_reset();
        test_first_bottle();
        test_batch();
        test_timeout();
        test_cork_empty();
        test_saturation();
        test_clr_mid_seal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bottling_line_ctrl.md
# bottling_line_ctrl

Parametrised single-station fill-and-seal controller for the bottling line: conveyor motor, fill valve, sealer and alarm driven by one Moore FSM. It also owns the cork stock counter and a configurable batch counter, which replaces the fixed twelve-unit dozen counter. It sits between the clock divider output and the station sensors/actuators at top level.

## Interface
Parameters:
- BATCH_SIZE, 12, bottles per batch (2..2**CNT_W)
- CNT_W, 4, width of unit_cnt
- BATCH_W, 8, width of batch_cnt (wraps)
- CORK_W, 8, width of cork stock counter
- CORK_LOAD, 15, corks added per refill pulse
- FILL_TIMEOUT, 255, max FILL cycles before fault (>=2)
- SEAL_CYCLES, 4, cycles ev is held per bottle (>=1)

Ports:
- clk  in  1  divided system clock; all logic on rising edge. One clock; reset is synchronous and active-high.
- clr  in  1  synchronous active-high reset
- start_stop  in  1  run enable (level)
- pg  in  1  bottle at station
- ch  in  1  bottle full
- rf  in  1  cork refill, one pulse per load
- ack  in  1  alarm acknowledge
- m  out  1  conveyor motor
- ve  out  1  fill valve
- ev  out  1  sealer
- al  out  1  alarm
- mef_estado  out  3  current state code
- unit_cnt  out  CNT_W  bottles in current batch
- batch_cnt  out  BATCH_W  completed batches
- batch_done  out  1  one-cycle pulse on batch completion
- cork_cnt  out  CORK_W  corks in stock

## Operation
- States (code): IDLE 0, TRANSPORT 1, FILL 2, SEAL 3, ALARM 4. Moore outputs: m=1 only in TRANSPORT; ve only in FILL; ev only in SEAL; al only in ALARM.
- Reset: state IDLE, all counters 0, pg_q 0, batch_done 0. All outputs therefore 0.
- IDLE: start_stop=1 with cork_cnt>0 -> TRANSPORT; start_stop=1 with cork_cnt=0 -> ALARM.
- TRANSPORT: start_stop=0 -> IDLE. Rising pg (pg=1, pg_q=0) -> FILL. A level-high pg without an edge is ignored.
- FILL: fill timer cleared on entry and incremented each cycle. ch=1 -> SEAL. ch=0 with timer=FILL_TIMEOUT-1 -> ALARM. ch wins on the same cycle. start_stop is ignored.
- SEAL: lasts exactly SEAL_CYCLES cycles. start_stop is ignored. On the last cycle:
  - cork_cnt decrements.
  - unit_cnt increments. If unit_cnt=BATCH_SIZE-1, it goes to 0, batch_cnt increments (wrapping) and batch_done pulses.
  - Next state is ALARM if the post-decrement stock is 0, else TRANSPORT if start_stop=1, else IDLE.
- ALARM: ack=1 with cork_cnt>0 -> IDLE. ack with empty stock keeps ALARM.
- rf, in any state: cork_cnt += CORK_LOAD, saturating at 2**CORK_W-1. When rf coincides with the SEAL consume, the net change is +CORK_LOAD-1, saturating.
- clr mid-operation: aborts any FILL/SEAL with no count update. Reset has priority over every input.

## Timing
- Transitions and counter updates take effect on the sampling edge. Outputs are valid from that edge, with no extra latency.
- pg rise sampled at edge k -> ve=1 after edge k.
- ch sampled at edge k -> ve=0 and ev=1 after edge k.
- ev high for exactly SEAL_CYCLES cycles. batch_done and count updates are visible after the edge that ends SEAL.
- Timeout: ve is high for exactly FILL_TIMEOUT cycles, then al=1.
- pg_q is registered every cycle, regardless of state.

## Structure
- Shared package: state code localparams (3-bit), output decode constants.
- Sub-module batch_counter: unit_cnt/batch_cnt/batch_done, parameters BATCH_SIZE, CNT_W and BATCH_W, inputs clk, clr and inc.
- Cork stock, fill timer and seal timer live in the top FSM module.

## Test plan
- Reset, then rf once (CORK_LOAD=15) and start_stop=1: TRANSPORT, m=1, cork_cnt=15; pg pulse -> ve=1; ch -> ev=1 for 4 cycles; then cork_cnt=14, unit_cnt=1.
- 12 full bottle cycles: after the 12th SEAL, unit_cnt=0, batch_cnt=1, batch_done high for exactly 1 cycle. Repeat with BATCH_SIZE=6.
- Hold ch=0 in FILL: al=1 after exactly 255 ve cycles. ack -> IDLE.
- cork_cnt=1, one bottle: after SEAL, ALARM. ack alone keeps ALARM; rf then ack -> IDLE with cork_cnt=15.
- rf on the last SEAL cycle with cork_cnt=250 (CORK_W=8): result 255, saturated.
- clr asserted mid-SEAL: next cycle IDLE, all outputs 0, counters 0. A pg held high across start does not retrigger FILL without a new edge.
